// File: rtl/snake_body_buffer.sv
// Snake body held as a circular buffer of DEPTH segments, presented head-first on one flat bus.
// Optional self-collision check is enabled by defining SNAKE_COLLIDE_EN.
module snake_body_buffer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 12,
    parameter int INIT_LEN = 1,
    parameter int LEN_W    = $clog2(DEPTH + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   move,
    input  logic                   grow,
    input  logic [WIDTH-1:0]       head_in,
    input  logic                   write_enable,
    input  logic [31:0]            index,
    input  logic [WIDTH-1:0]       value_in,
    output logic [DEPTH*WIDTH-1:0] value_out,
    output logic [LEN_W-1:0]       length,
    output logic                   full,
    output logic                   overflow,
    output logic                   collide
);

    localparam int HP_W = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] slot;
    logic [DEPTH-1:0][WIDTH-1:0] seg;
    logic [HP_W-1:0]             hp;
    logic [HP_W-1:0]             hp_dec;
    logic [HP_W-1:0]             wr_phys;
    logic [LEN_W-1:0]            len;
    logic                        wr_ok;
    logic                        grow_ok;

    // hp + offset never exceeds 2*DEPTH-2, so one conditional subtract suffices.
    function automatic logic [HP_W-1:0] wrap(input int p);
        return HP_W'((p >= DEPTH) ? p - DEPTH : p);
    endfunction

    assign hp_dec  = (hp == '0) ? HP_W'(DEPTH - 1) : hp - 1'b1;
    assign full    = (len == LEN_W'(DEPTH));
    assign grow_ok = grow && !full;
    assign wr_ok   = (index < 32'(len));
    assign wr_phys = wrap(int'(hp) + int'(index));
    assign length  = len;

    always_comb begin
        seg = '0;
        for (int i = 0; i < DEPTH; i++)
            seg[i] = slot[wrap(int'(hp) + i)];
    end

    always_comb begin
        value_out = '0;
        for (int i = 0; i < DEPTH; i++)
            if (LEN_W'(i) < len)
                value_out[i*WIDTH +: WIDTH] = seg[i];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            slot     <= '0;
            hp       <= '0;
            len      <= LEN_W'(INIT_LEN);
            overflow <= 1'b0;
        end else if (clear) begin
            slot     <= '0;
            hp       <= '0;
            len      <= LEN_W'(INIT_LEN);
            overflow <= 1'b0;
        end else begin
            overflow <= move && grow && full;
            if (move) begin
                hp           <= hp_dec;
                slot[hp_dec] <= head_in;
                if (grow_ok)
                    len <= len + 1'b1;
            end else if (write_enable && wr_ok) begin
                slot[wr_phys] <= value_in;
            end
        end
    end

`ifdef SNAKE_COLLIDE_EN
    logic [LEN_W-1:0] chk_len;
    logic             hit;

    // The tail vacates on a plain move (or a capped grow), so it cannot be hit.
    always_comb begin
        chk_len = grow_ok ? len : len - 1'b1;
        hit     = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if ((LEN_W'(i) < chk_len) && (seg[i] == head_in))
                hit = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            collide <= 1'b0;
        else if (clear)
            collide <= 1'b0;
        else
            collide <= move && hit;
    end
`else
    assign collide = 1'b0;
`endif

endmodule

// File: tb/tb_snake_body_buffer.sv
// Directed scoreboard bench for snake_body_buffer (DEPTH=12, WIDTH=32).
module tb_snake_body_buffer;

    localparam int WIDTH = 32;
    localparam int DEPTH = 12;
    localparam int LEN_W = $clog2(DEPTH + 1);
`ifdef SNAKE_COLLIDE_EN
    localparam logic COL_ON = 1'b1;
`else
    localparam logic COL_ON = 1'b0;
`endif

    logic                   clock = 1'b0;
    logic                   reset = 1'b0;
    logic                   clear = 1'b0;
    logic                   move = 1'b0;
    logic                   grow = 1'b0;
    logic [WIDTH-1:0]       head_in = '0;
    logic                   write_enable = 1'b0;
    logic [31:0]            index = '0;
    logic [WIDTH-1:0]       value_in = '0;
    logic [DEPTH*WIDTH-1:0] value_out;
    logic [LEN_W-1:0]       length;
    logic                   full;
    logic                   overflow;
    logic                   collide;

    snake_body_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INIT_LEN(1)) dut (
        .clock(clock), .reset(reset), .clear(clear), .move(move), .grow(grow),
        .head_in(head_in), .write_enable(write_enable), .index(index),
        .value_in(value_in), .value_out(value_out), .length(length),
        .full(full), .overflow(overflow), .collide(collide)
    );

    always #5 clock = ~clock;

    typedef struct {
        string                  name;
        logic [LEN_W-1:0]       len;
        logic                   full;
        logic                   ovf;
        logic                   col;
        logic [DEPTH*WIDTH-1:0] vout;
    } exp_t;

    exp_t             sb[$];
    exp_t             got_e;
    logic             chk = 1'b0;
    int               n_tests = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] es [DEPTH];

    // Monitor: pops one expectation each time the stimulus flags a check.
    always @(negedge clock) begin
        if (chk) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: got a check strobe, required a queued expectation");
            end else begin
                got_e = sb.pop_front();
                if (length !== got_e.len || full !== got_e.full || overflow !== got_e.ovf ||
                    collide !== got_e.col || value_out !== got_e.vout) begin
                    n_fail++;
                    $display("FAIL %s: got len=%0d full=%b ovf=%b col=%b segs=%h, required len=%0d full=%b ovf=%b col=%b segs=%h",
                             got_e.name, length, full, overflow, collide, value_out,
                             got_e.len, got_e.full, got_e.ovf, got_e.col, got_e.vout);
                end
            end
        end
    end

    task automatic expect_state(input string name, input int n, input logic ovf, input logic col);
        exp_t e;
        e.name = name;
        e.len  = LEN_W'(n);
        e.full = (n == DEPTH);
        e.ovf  = ovf;
        e.col  = col;
        e.vout = '0;
        for (int i = 0; i < DEPTH; i++) e.vout[i*WIDTH +: WIDTH] = es[i];
        sb.push_back(e);
        chk = 1'b1;
        @(negedge clock);
        #1 chk = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        move = 1'b0; grow = 1'b0; clear = 1'b0; write_enable = 1'b0;
    endtask

    task automatic do_move(input int h, input logic g);
        head_in = WIDTH'(h); grow = g; move = 1'b1;
        cycle();
        idle();
    endtask

    task automatic build4();
        clear = 1'b1;
        cycle();
        idle();
        do_move(1, 1'b1); do_move(2, 1'b1); do_move(3, 1'b1); do_move(4, 1'b0);
    endtask

    initial begin
        cycle(); cycle();
        es = '{0,0,0,0,0,0,0,0,0,0,0,0};
        expect_state("reset_hold", 1, 1'b0, 1'b0);
        reset = 1'b1;
        cycle();
        expect_state("after_reset", 1, 1'b0, 1'b0);

        for (int k = 1; k <= 11; k++) do_move(k, 1'b1);
        es = '{11,10,9,8,7,6,5,4,3,2,1,0};
        expect_state("grow_to_full", 12, 1'b0, 1'b0);

        do_move(99, 1'b1);
        es = '{99,11,10,9,8,7,6,5,4,3,2,1};
        expect_state("overflow_pulse", 12, 1'b1, 1'b0);
        expect_state("overflow_one_cycle", 12, 1'b0, 1'b0);

        // Full grow-move onto the vacating tail value: overflow but no collision.
        do_move(1, 1'b1);
        es = '{1,99,11,10,9,8,7,6,5,4,3,2};
        expect_state("full_tail_excluded", 12, 1'b1, 1'b0);

        clear = 1'b1;
        cycle();
        idle();
        es = '{0,0,0,0,0,0,0,0,0,0,0,0};
        expect_state("clear", 1, 1'b0, 1'b0);

        do_move(100, 1'b1); do_move(101, 1'b1);
        es = '{101,100,0,0,0,0,0,0,0,0,0,0};
        expect_state("len3", 3, 1'b0, 1'b0);

        for (int k = 1; k <= 20; k++) do_move(k, 1'b0);
        es = '{20,19,18,0,0,0,0,0,0,0,0,0};
        expect_state("plain_move_wrap", 3, 1'b0, 1'b0);

        write_enable = 1'b1; index = 1; value_in = 'hAB;
        cycle(); idle();
        es = '{20,'hAB,18,0,0,0,0,0,0,0,0,0};
        expect_state("write_idx1", 3, 1'b0, 1'b0);

        write_enable = 1'b1; index = 3; value_in = 'hCD;
        cycle(); idle();
        expect_state("write_idx_eq_len", 3, 1'b0, 1'b0);

        write_enable = 1'b1; index = 5; value_in = 'hCD;
        cycle(); idle();
        expect_state("write_idx5", 3, 1'b0, 1'b0);

        head_in = 21; move = 1'b1; write_enable = 1'b1; index = 0; value_in = 'hEE;
        cycle(); idle();
        es = '{21,20,'hAB,0,0,0,0,0,0,0,0,0};
        expect_state("move_over_write", 3, 1'b0, 1'b0);

        grow = 1'b1;
        cycle(); idle();
        expect_state("grow_no_move", 3, 1'b0, 1'b0);

        // head_in matches a body segment: clear must also suppress the collision check.
        clear = 1'b1; move = 1'b1; grow = 1'b1; head_in = 20; write_enable = 1'b1; index = 0;
        cycle(); idle();
        es = '{0,0,0,0,0,0,0,0,0,0,0,0};
        expect_state("clear_over_move", 1, 1'b0, 1'b0);

        build4();
        es = '{4,3,2,1,0,0,0,0,0,0,0,0};
        expect_state("build4", 4, 1'b0, 1'b0);
        do_move(3, 1'b0);
        es = '{3,4,3,2,0,0,0,0,0,0,0,0};
        expect_state("collide_hit", 4, 1'b0, COL_ON);
        expect_state("collide_one_cycle", 4, 1'b0, 1'b0);

        build4();
        do_move(1, 1'b0);
        es = '{1,4,3,2,0,0,0,0,0,0,0,0};
        expect_state("tail_vacates", 4, 1'b0, 1'b0);

        build4();
        do_move(1, 1'b1);
        es = '{1,4,3,2,1,0,0,0,0,0,0,0};
        expect_state("tail_kept_grow", 5, 1'b0, COL_ON);

        cycle();
        head_in = 7; move = 1'b1; grow = 1'b1;
        #2 reset = 1'b0;
        es = '{0,0,0,0,0,0,0,0,0,0,0,0};
        expect_state("reset_mid_move", 1, 1'b0, 1'b0);
        idle();
        cycle();
        expect_state("reset_held", 1, 1'b0, 1'b0);
        reset = 1'b1;
        cycle();
        expect_state("post_reset", 1, 1'b0, 1'b0);

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover expectations, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
